// File: rtl/ql_bl_wl_prog_driver_if.sv
// -----------------------------------------------------------------------------
// ql_bl_wl_prog_driver_if
// Bundles the control, bitstream-input and fabric-output signals of the BL/WL
// programming driver.
//   start    : begin a full-array program sequence (sampled in IDLE only)
//   abort    : cancel a running sequence
//   in_data  : bitstream word, LSB chunk of the row first
//   in_valid : in_data valid
//   in_ready : driver accepts in_data this cycle
//   bl_out   : BL bus to the fabric
//   wl_out   : WL strobes to the fabric, one-hot or zero
//   row_idx  : row currently being loaded or written
//   busy     : sequence in progress
//   done     : one-cycle pulse after the last row is written
// Modports: master = bitstream source / controller, slave = the driver.
// -----------------------------------------------------------------------------
interface ql_bl_wl_prog_driver_if #(
  parameter int NUM_BL = 315,
  parameter int NUM_WL = 4,
  parameter int DATA_W = 32
);
  localparam int ROW_W = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;

  logic              start;
  logic              abort;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [NUM_BL-1:0] bl_out;
  logic [NUM_WL-1:0] wl_out;
  logic [ROW_W-1:0]  row_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, in_data, in_valid,
    input  in_ready, bl_out, wl_out, row_idx, busy, done
  );

  modport slave (
    input  start, abort, in_data, in_valid,
    output in_ready, bl_out, wl_out, row_idx, busy, done
  );
endinterface

// File: rtl/ql_bl_wl_prog_driver.sv
// -----------------------------------------------------------------------------
// ql_bl_wl_prog_driver
// Programming-side driver for the BL/WL configuration memory bank. Assembles
// one BL row from a word-streamed bitstream, holds it on bl_out, pulses the
// row's WL line for WL_PULSE_CYCLES clocks, then moves to the next row. After
// the last row it pulses done and returns to IDLE.
// Ports:
//   prog_clk : programming clock, all logic on the rising edge
//   pReset   : asynchronous, active-high reset
//   bus      : slave side of ql_bl_wl_prog_driver_if (control, stream, fabric)
// Sequence per row: LOAD (WORDS handshakes) -> SETUP -> PULSE -> HOLD.
// -----------------------------------------------------------------------------
module ql_bl_wl_prog_driver #(
  parameter int NUM_BL          = 315,
  parameter int NUM_WL          = 4,
  parameter int DATA_W          = 32,
  parameter int WL_PULSE_CYCLES = 2
) (
  input  logic                     prog_clk,
  input  logic                     pReset,
  ql_bl_wl_prog_driver_if.slave    bus
);

  localparam int WORDS  = (NUM_BL + DATA_W - 1) / DATA_W;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int ROW_W  = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
  localparam int PCNT_W = (WL_PULSE_CYCLES > 1) ? $clog2(WL_PULSE_CYCLES) : 1;

  localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(WORDS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(NUM_WL - 1);
  localparam logic [PCNT_W-1:0] LAST_PULSE = PCNT_W'(WL_PULSE_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        r_state;
  logic [WCNT_W-1:0] r_word_cnt;
  logic [ROW_W-1:0]  r_row_idx;
  logic [PCNT_W-1:0] r_pulse_cnt;
  logic [NUM_BL-1:0] r_bl_out;
  logic [NUM_WL-1:0] r_wl_out;
  logic              r_busy;
  logic              r_done;

  logic              w_in_ready;
  logic              w_accept;
  logic [NUM_BL-1:0] w_bl_merged;
  logic [NUM_WL-1:0] w_wl_onehot;

  // Abort gates in_ready so a same-cycle handshake is never accepted.
  assign w_in_ready  = (r_state == S_LOAD) && !bus.abort;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_wl_onehot = NUM_WL'(1) << r_row_idx;

  // Current BL register with the addressed DATA_W chunk replaced by in_data.
  // Chunk positions at or above NUM_BL simply have no destination bit, which
  // is how the padding bits of the final word are discarded.
  for (genvar g = 0; g < NUM_BL; g++) begin : g_merge
    localparam int CHUNK = g / DATA_W;
    assign w_bl_merged[g] = (r_word_cnt == WCNT_W'(CHUNK)) ? bus.in_data[g % DATA_W]
                                                          : r_bl_out[g];
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would let later statements see
  // half-updated state and break the registered-output timing.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state     <= S_IDLE;
      r_word_cnt  <= '0;
      r_row_idx   <= '0;
      r_pulse_cnt <= '0;
      r_bl_out    <= '0;
      r_wl_out    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (bus.abort && (r_state != S_IDLE)) begin
      // Cancel from any active state: drop the WL strobe and clear the row
      // image in the same edge; no done pulse is produced.
      r_state     <= S_IDLE;
      r_word_cnt  <= '0;
      r_row_idx   <= '0;
      r_pulse_cnt <= '0;
      r_bl_out    <= '0;
      r_wl_out    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Start beats a same-cycle abort because abort is ignored in IDLE.
          if (bus.start) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_row_idx  <= '0;
            r_word_cnt <= '0;
            r_bl_out   <= '0;
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            r_bl_out <= w_bl_merged;
            if (r_word_cnt == LAST_WORD) begin
              r_state    <= S_SETUP;
              r_word_cnt <= '0;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end

        // One settling cycle so bl_out is stable before the WL edge.
        S_SETUP: begin
          r_state     <= S_PULSE;
          r_wl_out    <= w_wl_onehot;
          r_pulse_cnt <= '0;
        end

        S_PULSE: begin
          if (r_pulse_cnt == LAST_PULSE) begin
            r_state     <= S_HOLD;
            r_wl_out    <= '0;
            r_pulse_cnt <= '0;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + 1'b1;
          end
        end

        // One hold cycle after WL falls before bl_out may change again.
        // bl_out is deliberately not cleared between rows.
        S_HOLD: begin
          if (r_row_idx == LAST_ROW) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_LOAD;
            r_row_idx  <= r_row_idx + 1'b1;
            r_word_cnt <= '0;
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_bl_out  <= '0;
          r_row_idx <= '0;
        end

        default: begin
          r_state     <= S_IDLE;
          r_word_cnt  <= '0;
          r_row_idx   <= '0;
          r_pulse_cnt <= '0;
          r_bl_out    <= '0;
          r_wl_out    <= '0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.bl_out   = r_bl_out;
  assign bus.wl_out   = r_wl_out;
  assign bus.row_idx  = r_row_idx;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_ql_bl_wl_prog_driver.sv
// -----------------------------------------------------------------------------
// tb_ql_bl_wl_prog_driver
// Directed bench for ql_bl_wl_prog_driver at default parameters. Row 0 is
// driven from a cycle-by-cycle vector table; later rows, gapped streams,
// abort and asynchronous reset use hand-written sequences. Inputs change on
// the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_ql_bl_wl_prog_driver;

  localparam int NUM_BL = 315;
  localparam int NUM_WL = 4;
  localparam int DATA_W = 32;
  localparam int PULSE  = 2;
  localparam int WORDS  = 10;
  localparam int BW     = NUM_BL;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;
  always #5 prog_clk = ~prog_clk;

  ql_bl_wl_prog_driver_if #(.NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .DATA_W(DATA_W)) bus ();

  ql_bl_wl_prog_driver #(
    .NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .DATA_W(DATA_W), .WL_PULSE_CYCLES(PULSE)
  ) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference row image: padded to whole words, truncated when compared.
  logic [WORDS*DATA_W-1:0] pad;
  int                      mw;
  logic [BW-1:0]           model;
  assign model = pad[BW-1:0];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {in_ready, wl_out, busy, done, row_idx}
  function automatic logic [8:0] outs();
    return {bus.in_ready, bus.wl_out, bus.busy, bus.done, bus.row_idx};
  endfunction

  function automatic logic [8:0] pack(input logic r, input logic [3:0] w, input logic b,
                                      input logic d, input logic [1:0] row);
    return {r, w, b, d, row};
  endfunction

  // Update the reference image from what the driver will accept this cycle.
  task automatic observe();
    if (bus.start && !bus.busy) begin
      pad = '0;
      mw  = 0;
    end
    if (bus.in_valid && bus.in_ready) begin
      pad[mw*DATA_W +: DATA_W] = bus.in_data;
      mw = (mw + 1) % WORDS;
    end
  endtask

  // Invariant monitor: one-hot WL, and bl_out frozen across each pulse window.
  bit            mon_en = 1'b0;
  logic [BW-1:0] prev_bl = '0;
  logic [3:0]    prev_wl = '0;
  always @(negedge prog_clk) begin
    #2;
    if (mon_en && !pReset) begin
      if (bus.wl_out != 4'b0)
        check("wl_onehot", BW'($countones(bus.wl_out)), BW'(1));
      if (bus.wl_out != 4'b0 || prev_wl != 4'b0)
        check("bl_stable", bus.bl_out, prev_bl);
    end
    prev_bl = bus.bl_out;
    prev_wl = bus.wl_out;
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic        e_ready;
    logic [3:0]  e_wl;
    logic        e_busy;
    logic        e_done;
    logic [1:0]  e_row;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(input logic s, input logic v, input logic [31:0] d,
                               input logic er, input logic [3:0] ew, input logic eb,
                               input logic ed, input logic [1:0] erow);
    vec_t x;
    x.start = s; x.valid = v; x.data = d;
    x.e_ready = er; x.e_wl = ew; x.e_busy = eb; x.e_done = ed; x.e_row = erow;
    return x;
  endfunction

  task automatic start_seq();
    @(negedge prog_clk);
    bus.start = 1'b1; bus.abort = 1'b0; bus.in_valid = 1'b0;
    #1; observe();
    check("start_idle", BW'(outs()), BW'(pack(0, 4'b0, 0, 0, 2'd0)));
  endtask

  // Stream one row (optionally with random valid gaps), then check SETUP,
  // PULSE, HOLD and the following cycle. mode 1 aborts on the first PULSE
  // cycle; mode 2 asserts pReset between edges of the first PULSE cycle.
  task automatic run_row(input int row, input bit gaps, input logic [31:0] base, input int mode);
    int got;
    int guard;
    int seen;
    logic [8:0] e;
    got = 0; guard = 0;
    while (got < WORDS && guard < 400) begin
      @(negedge prog_clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = base + 32'(got);
      #1;
      if (bus.in_valid && bus.in_ready) got++;
      observe();
      guard++;
    end
    if (got < WORDS) begin
      checks++; failures++;
      $display("FAIL row%0d_load_timeout: got %0d words required %0d", row, got, WORDS);
      return;
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge prog_clk);
      bus.start    = 1'b0;
      bus.in_valid = (c != 5);
      bus.in_data  = 32'hBAD0_0000 + 32'(c);
      bus.abort    = (c == 2 && mode == 1);
      #1; observe();
      e = pack(0, 4'b0, 1, 0, 2'(row));
      if (c == 2 || c == 3) e = pack(0, 4'b1 << row, 1, 0, 2'(row));
      if (c == 5) e = (row == NUM_WL - 1) ? pack(0, 4'b0, 1, 1, 2'(row))
                                          : pack(1, 4'b0, 1, 0, 2'(row + 1));
      check($sformatf("row%0d_c%0d", row, c), BW'(outs()), BW'(e));
      if (c <= 4) check($sformatf("row%0d_bl_c%0d", row, c), bus.bl_out, model);
      if (c == 2 && mode == 1) begin
        @(negedge prog_clk);
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        #1;
        check("abort_idle", BW'(outs()), BW'(pack(0, 4'b0, 0, 0, 2'd0)));
        check("abort_bl", bus.bl_out, '0);
        seen = 0;
        repeat (4) begin
          @(negedge prog_clk); #1;
          if (bus.done) seen++;
        end
        check("abort_no_done", BW'(seen), BW'(0));
        return;
      end
      if (c == 2 && mode == 2) begin
        #2; pReset = 1'b1;
        #1;
        check("rst_mid_pulse_outs", BW'(outs()), BW'(pack(0, 4'b0, 0, 0, 2'd0)));
        check("rst_mid_pulse_bl", bus.bl_out, '0);
        @(negedge prog_clk);
        pReset = 1'b0;
        return;
      end
    end
    if (row == NUM_WL - 1) begin
      @(negedge prog_clk);
      bus.in_valid = 1'b0;
      #1;
      check("after_done_idle", BW'(outs()), BW'(pack(0, 4'b0, 0, 0, 2'd0)));
      check("after_done_bl", bus.bl_out, '0);
    end
  endtask

  task automatic program_all(input bit gaps, input logic [31:0] seed_base);
    start_seq();
    for (int r = 0; r < NUM_WL; r++)
      run_row(r, gaps, seed_base + 32'(r) * 32'h0100_0000, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    pad = '0; mw = 0;

    // Reset state
    repeat (2) @(negedge prog_clk);
    #1;
    check("reset_outs", BW'(outs()), BW'(pack(0, 4'b0, 0, 0, 2'd0)));
    check("reset_bl", bus.bl_out, '0);
    @(negedge prog_clk);
    pReset = 1'b0;
    mon_en = 1'b1;

    // Row 0 vector table. Junk words with in_valid high in IDLE, SETUP,
    // PULSE and HOLD must be ignored; a start pulse in LOAD must not restart.
    vecs[0] = mkv(1, 1, 32'hDEAD_BEEF, 0, 4'b0000, 0, 0, 2'd0);
    for (int k = 0; k < WORDS; k++)
      vecs[k+1] = mkv(k == 4, 1, 32'hA000_0000 + 32'(k), 1, 4'b0000, 1, 0, 2'd0);
    vecs[11] = mkv(0, 1, 32'hDEAD_BEEF, 0, 4'b0000, 1, 0, 2'd0);
    vecs[12] = mkv(0, 1, 32'hDEAD_BEEF, 0, 4'b0001, 1, 0, 2'd0);
    vecs[13] = mkv(0, 1, 32'hDEAD_BEEF, 0, 4'b0001, 1, 0, 2'd0);
    vecs[14] = mkv(0, 1, 32'hDEAD_BEEF, 0, 4'b0000, 1, 0, 2'd0);
    vecs[15] = mkv(0, 0, 32'h0000_0000, 1, 4'b0000, 1, 0, 2'd1);

    for (int i = 0; i < 16; i++) begin
      @(negedge prog_clk);
      bus.start    = vecs[i].start;
      bus.in_valid = vecs[i].valid;
      bus.in_data  = vecs[i].data;
      #1; observe();
      check($sformatf("vec%0d", i), BW'(outs()),
            BW'(pack(vecs[i].e_ready, vecs[i].e_wl, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_row)));
    end
    check("row0_bl_lsw", BW'(bus.bl_out[31:0]), BW'(32'hA000_0000));
    check("row0_bl_msw", BW'(bus.bl_out[314:288]), BW'(27'h000_0009));
    check("row0_bl_full", bus.bl_out, model);

    // Remaining rows of the first full program
    for (int r = 1; r < NUM_WL; r++)
      run_row(r, 1'b0, 32'h5000_0000 + 32'(r) * 32'h0100_0000, 0);

    // Gapped stream, 4 rows
    program_all(1'b1, $urandom);

    // Abort on the first cycle of row 2's pulse, then a clean program
    start_seq();
    run_row(0, 1'b0, 32'h1100_0000, 0);
    mon_en = 1'b1;
    run_row(1, 1'b0, 32'h2200_0000, 0);
    mon_en = 1'b0;
    run_row(2, 1'b0, 32'h3300_0000, 1);
    pad = '0;
    mon_en = 1'b1;
    program_all(1'b0, 32'h7700_0000);

    // Abort beats a same-cycle handshake; start beats abort in IDLE
    @(negedge prog_clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    #1; observe();
    @(negedge prog_clk);
    bus.start = 1'b0; bus.abort = 1'b1; bus.in_valid = 1'b1;
    #1;
    check("start_beats_abort", BW'(bus.busy), BW'(1));
    check("abort_gates_ready", BW'(bus.in_ready), BW'(0));
    @(negedge prog_clk);
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("abort_load_idle", BW'(outs()), BW'(pack(0, 4'b0, 0, 0, 2'd0)));

    // Asynchronous reset mid-pulse
    mon_en = 1'b0;
    start_seq();
    run_row(0, 1'b0, 32'h9900_0000, 2);
    @(negedge prog_clk);
    #1;
    check("post_reset_idle", BW'(outs()), BW'(pack(0, 4'b0, 0, 0, 2'd0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
